// File: rtl/clamp_fp64_mc.sv
// Multi-channel pipelined fp64 limiter with per-channel [lo, hi] windows and saturation counters.
// Optional macro CLAMP_NAN_FLUSH_EN: NaN inputs are replaced by the channel's lower bound.
module clamp_fp64_mc #(
  parameter int          N_CH    = 4,
  parameter int          CH_W    = 2,
  parameter int          CNT_W   = 16,
  parameter logic [63:0] LO_INIT = 64'h0000000000000000,
  parameter logic [63:0] HI_INIT = 64'h7FF0000000000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_sel,
  input  logic [63:0]      cfg_data,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [63:0]      out_data,
  output logic [1:0]       out_flag,
  input  logic [CH_W-1:0]  cnt_ch,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_lo,
  output logic [CNT_W-1:0] cnt_hi
);

  // Monotonic mapping of a double onto an unsigned integer so one compare orders reals.
  function automatic logic [63:0] orderKey(input logic [63:0] x);
    return x[63] ? ~x : {1'b1, x[62:0]};
  endfunction

  function automatic logic chInRange(input logic [CH_W-1:0] c);
    return 32'(c) < N_CH;
  endfunction

  logic [63:0]      lo_q [N_CH];
  logic [63:0]      hi_q [N_CH];
  logic [63:0]      loSel, hiSel;

  logic             s1_valid_q;
  logic [CH_W-1:0]  s1_ch_q;
  logic [63:0]      s1_data_q, s1_lo_q, s1_hi_q;
  logic             s1Lt, s1Gt, s1Nan;

  logic             s2_valid_q;
  logic [CH_W-1:0]  s2_ch_q;
  logic [63:0]      s2_data_q, s2_lo_q, s2_hi_q;
  logic             s2_lt_q, s2_gt_q, s2_nan_q;

  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [63:0]      out_data_q, out_data_d;
  logic [1:0]       out_flag_q, out_flag_d;

  logic [CNT_W-1:0] cnt_lo_q [N_CH];
  logic [CNT_W-1:0] cnt_hi_q [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        lo_q[i] <= LO_INIT;
        hi_q[i] <= HI_INIT;
      end
    end else if (cfg_we && chInRange(cfg_ch)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (32'(cfg_ch) == i) begin
          if (cfg_sel) hi_q[i] <= cfg_data;
          else         lo_q[i] <= cfg_data;
        end
      end
    end
  end

  always_comb begin
    loSel = LO_INIT;
    hiSel = HI_INIT;
    for (int i = 0; i < N_CH; i++) begin
      if (32'(in_ch) == i) begin
        loSel = lo_q[i];
        hiSel = hi_q[i];
      end
    end
  end

  always_comb begin
    s1Lt  = orderKey(s1_data_q) < orderKey(s1_lo_q);
    s1Gt  = orderKey(s1_data_q) > orderKey(s1_hi_q);
    s1Nan = (s1_data_q[62:52] == 11'h7FF) && (s1_data_q[51:0] != 52'd0);
  end

  // Bounds are captured alongside the sample, so a same-cycle cfg write only affects later samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_data_q  <= '0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
      s2_lo_q    <= '0;
      s2_hi_q    <= '0;
      s2_lt_q    <= 1'b0;
      s2_gt_q    <= 1'b0;
      s2_nan_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid && chInRange(in_ch);
      s1_ch_q    <= in_ch;
      s1_data_q  <= in_data;
      s1_lo_q    <= loSel;
      s1_hi_q    <= hiSel;
      s2_valid_q <= s1_valid_q;
      s2_ch_q    <= s1_ch_q;
      s2_data_q  <= s1_data_q;
      s2_lo_q    <= s1_lo_q;
      s2_hi_q    <= s1_hi_q;
      s2_lt_q    <= s1Lt;
      s2_gt_q    <= s1Gt;
      s2_nan_q   <= s1Nan;
    end
  end

  always_comb begin
    out_data_d = s2_data_q;
    out_flag_d = 2'b00;
`ifdef CLAMP_NAN_FLUSH_EN
    if (s2_nan_q || s2_lt_q) begin
`else
    if (s2_nan_q) begin
      out_data_d = s2_data_q;
      out_flag_d = 2'b00;
    end else if (s2_lt_q) begin
`endif
      out_data_d = s2_lo_q;
      out_flag_d = 2'b01;
    end else if (s2_gt_q) begin
      out_data_d = s2_hi_q;
      out_flag_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_flag_q  <= 2'b00;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_ch_q   <= s2_ch_q;
        out_data_q <= out_data_d;
        out_flag_q <= out_flag_d;
      end
    end
  end

  // Counters advance on the same edge that presents the output; a clear overrides an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_lo_q[i] <= '0;
        cnt_hi_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr && 32'(cnt_ch) == i) begin
          cnt_lo_q[i] <= '0;
          cnt_hi_q[i] <= '0;
        end else if (s2_valid_q && 32'(s2_ch_q) == i) begin
          if (out_flag_d[0] && cnt_lo_q[i] != '1) cnt_lo_q[i] <= cnt_lo_q[i] + 1'b1;
          if (out_flag_d[1] && cnt_hi_q[i] != '1) cnt_hi_q[i] <= cnt_hi_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_lo = '0;
    cnt_hi = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (32'(cnt_ch) == i) begin
        cnt_lo = cnt_lo_q[i];
        cnt_hi = cnt_hi_q[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_flag  = out_flag_q;

endmodule

// File: tb/tb_clamp_fp64_mc.sv
// Directed self-checking bench for clamp_fp64_mc: 3 channels on a 2-bit tag, 4-bit counters.
module tb_clamp_fp64_mc;

  localparam int N_CH  = 3;
  localparam int CH_W  = 2;
  localparam int CNT_W = 4;

  localparam logic [63:0] P0    = 64'h0000000000000000;
  localparam logic [63:0] NZERO = 64'h8000000000000000;
  localparam logic [63:0] NEG2  = 64'hC000000000000000;
  localparam logic [63:0] NEG5  = 64'hC014000000000000;
  localparam logic [63:0] P1_5  = 64'h3FF8000000000000;
  localparam logic [63:0] P2    = 64'h4000000000000000;
  localparam logic [63:0] P5    = 64'h4014000000000000;
  localparam logic [63:0] P10   = 64'h4024000000000000;
  localparam logic [63:0] PINF  = 64'h7FF0000000000000;
  localparam logic [63:0] NINF  = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] NNAN  = 64'hFFF8000000000000;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we, cfg_sel, in_valid, cnt_clr;
  logic [CH_W-1:0]  cfg_ch, in_ch, cnt_ch;
  logic [63:0]      cfg_data, in_data;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [63:0]      out_data;
  logic [1:0]       out_flag;
  logic [CNT_W-1:0] cnt_lo, cnt_hi;

  int errors = 0;
  int checks = 0;

  // Expected output three accepted cycles back; index 2 is what should be on the outputs now.
  logic             pv [3];
  logic [63:0]      pd [3];
  logic [1:0]       pf [3];
  logic [CH_W-1:0]  pc [3];

  always #5 clk = ~clk;

  clamp_fp64_mc #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_flag(out_flag),
    .cnt_ch(cnt_ch), .cnt_clr(cnt_clr), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pd[i] = '0; pf[i] = '0; pc[i] = '0;
    end
  endtask

  // One clock of stimulus; cfg_we/cnt_clr strobes set by the caller last exactly this cycle.
  task automatic applyStimulus(input logic v, input logic [CH_W-1:0] ch, input logic [63:0] d,
                               input logic [63:0] ed, input logic [1:0] ef);
    in_valid = v;
    in_ch    = ch;
    in_data  = d;
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; pd[i] = pd[i-1]; pf[i] = pf[i-1]; pc[i] = pc[i-1];
    end
    pv[0] = v && (32'(ch) < N_CH);
    pd[0] = ed;
    pf[0] = ef;
    pc[0] = ch;
    @(negedge clk);
    cfg_we   = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    checkOutput("out_valid", 64'(out_valid), 64'(pv[2]));
    if (pv[2]) begin
      checkOutput("out_data", out_data, pd[2]);
      checkOutput("out_flag", 64'(out_flag), 64'(pf[2]));
      checkOutput("out_ch", 64'(out_ch), 64'(pc[2]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 2'b00);
  endtask

  task automatic writeBound(input logic [CH_W-1:0] ch, input logic sel, input logic [63:0] d);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = d;
    idle(1);
  endtask

  task automatic checkCounts(input logic [CH_W-1:0] ch, input int expLo, input int expHi);
    cnt_ch = ch;
    #1;
    checkOutput("cnt_lo", 64'(cnt_lo), 64'(expLo));
    checkOutput("cnt_hi", 64'(cnt_hi), 64'(expHi));
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_ch = '0; in_data = '0; cnt_ch = '0; cnt_clr = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_flag", 64'(out_flag), 64'd0);
    checkCounts(0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Default window [+0, +inf]
    applyStimulus(1'b1, 0, NEG2, P0, 2'b01);
    idle(2);
    checkCounts(0, 1, 0);
    applyStimulus(1'b1, 0, PINF, PINF, 2'b00);
    applyStimulus(1'b1, 0, NZERO, P0, 2'b01);
    idle(2);
    checkCounts(0, 2, 0);
    cnt_ch = 0; cnt_clr = 1'b1;
    idle(1);
    checkCounts(0, 0, 0);
    applyStimulus(1'b1, 3, NEG2, P0, 2'b01);
    idle(2);
    checkCounts(3, 0, 0);

    // Window clamp on ch2
    writeBound(2, 1'b0, P1_5);
    writeBound(2, 1'b1, P5);
    applyStimulus(1'b1, 2, P10, P5, 2'b10);
    applyStimulus(1'b1, 2, P2, P2, 2'b00);
    applyStimulus(1'b1, 2, NEG2, P1_5, 2'b01);
    applyStimulus(1'b1, 2, P5, P5, 2'b00);
    idle(2);
    checkCounts(2, 1, 1);

    // Interleaved channels
    writeBound(0, 1'b1, P1_5);
    writeBound(1, 1'b1, P10);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 0, P5, P1_5, 2'b10);
      else            applyStimulus(1'b1, 1, P5, P5, 2'b00);
    end
    idle(2);
    checkCounts(0, 0, 4);
    checkCounts(1, 0, 0);

    // Same-cycle bound write does not affect the sample it accompanies
    cfg_we = 1'b1; cfg_ch = 1; cfg_sel = 1'b0; cfg_data = NEG5;
    applyStimulus(1'b1, 1, NEG2, P0, 2'b01);
    applyStimulus(1'b1, 1, NEG2, NEG2, 2'b00);
    applyStimulus(1'b1, 1, NINF, NEG5, 2'b01);
    applyStimulus(1'b1, 0, PINF, P1_5, 2'b10);
    idle(2);
    checkCounts(1, 2, 0);

    // Counter saturation and clear-beats-increment
    cnt_ch = 2; cnt_clr = 1'b1;
    idle(1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2, NEG2, P1_5, 2'b01);
    idle(2);
    checkCounts(2, 15, 0);
    applyStimulus(1'b1, 2, NEG2, P1_5, 2'b01);
    applyStimulus(1'b1, 2, NEG2, P1_5, 2'b01);
    cnt_ch = 2; cnt_clr = 1'b1;
    applyStimulus(1'b1, 2, NEG2, P1_5, 2'b01);
    checkCounts(2, 0, 0);
    idle(2);
    checkCounts(2, 2, 0);

    // NaN handling on ch0 (lo = +0, hi = 1.5)
`ifdef CLAMP_NAN_FLUSH_EN
    applyStimulus(1'b1, 0, QNAN, P0, 2'b01);
    applyStimulus(1'b1, 0, NNAN, P0, 2'b01);
    idle(2);
    checkCounts(0, 2, 5);
`else
    applyStimulus(1'b1, 0, QNAN, QNAN, 2'b00);
    applyStimulus(1'b1, 0, NNAN, NNAN, 2'b00);
    idle(2);
    checkCounts(0, 0, 5);
`endif

    // Reset with samples in flight
    applyStimulus(1'b1, 0, NEG2, P0, 2'b01);
    applyStimulus(1'b1, 0, NEG2, P0, 2'b01);
    in_valid = 1'b1; in_ch = 0; in_data = NEG2;
    #1 rst = 1'b1;
    clearModel();
    #1;
    checkOutput("rst_flight_valid", 64'(out_valid), 64'd0);
    checkCounts(0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    checkCounts(0, 0, 0);
    applyStimulus(1'b1, 1, NEG2, P0, 2'b01);
    applyStimulus(1'b1, 0, PINF, PINF, 2'b00);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clamp_fp64_mc.md
# clamp_fp64_mc

Multi-channel, fully pipelined IEEE-754 double-precision limiter. Each sample is tagged with a channel index and clamped to that channel's programmable [lower, upper] window. It also reports which bound was applied and keeps per-channel saturation-event counters. The block sits in the OPT solver datapath between the arithmetic stages and the state-update logic. It accepts one sample per clock from the interleaved channel stream.

## Interface

Parameters:
- N_CH, 4, number of channels (2..16)
- CH_W, 2, channel index width; must satisfy 2^CH_W >= N_CH
- CNT_W, 16, width of each saturation counter
- LO_INIT, 64'h0000000000000000, reset value of every lower bound (+0.0)
- HI_INIT, 64'h7FF0000000000000, reset value of every upper bound (+inf)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  bound write strobe
- cfg_ch  in  CH_W  channel to write
- cfg_sel  in  1  0 = lower bound, 1 = upper bound
- cfg_data  in  64  bound value (IEEE-754 double)
- in_valid  in  1  input sample valid
- in_ch  in  CH_W  input channel tag
- in_data  in  64  input sample
- out_valid  out  1  output valid
- out_ch  out  CH_W  output channel tag
- out_data  out  64  clamped sample
- out_flag  out  2  [0] = lower bound applied, [1] = upper bound applied
- cnt_ch  in  CH_W  counter read/clear select
- cnt_clr  in  1  clear both counters of cnt_ch
- cnt_lo  out  CNT_W  lower-saturation count of cnt_ch (combinational read)
- cnt_hi  out  CNT_W  upper-saturation count of cnt_ch (combinational read)

## Operation

- Ordering key: sign=0 -> {1'b1, x[62:0]}; sign=1 -> ~x. Keys are compared unsigned. Consequences:
  - -0.0 orders below +0.0.
  - ±inf order at the extremes.
- Clamp rule:
  - key(x) < key(lo) -> out = lo, flag = 01.
  - Else key(x) > key(hi) -> out = hi, flag = 10.
  - Else out = x, flag = 00.
  - The lower test has priority. If lo > hi, in-range inputs pass unchanged, below-lo inputs get lo, and above-hi inputs get hi.
- NaN input (exp = 7FF, mantissa != 0): handling is set by the macro in Configuration.
- Pipeline, with no backpressure and one sample per clock sustained:
  - S1: register in_data, in_ch, in_valid; fetch lo/hi of in_ch; form keys.
  - S2: register the compare results.
  - S3: register out_data, out_flag, out_ch, out_valid; update counters.
- Bound register file:
  - N_CH × 2 × 64 bits, written on cfg_we at the clock edge.
  - Channel indices >= N_CH are ignored, both for writes and for inputs. An input with in_ch >= N_CH gives out_valid = 0.
- Counters:
  - Per channel, incremented at S3 when out_valid and the matching flag bit is set.
  - Saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr zeroes both counters of cnt_ch at the next edge. If a clear and an increment hit the same channel in the same cycle, the clear wins and the count becomes 0.

## Timing

- Latency: in_valid at edge t -> out_valid high after edge t+3, then held for exactly one cycle per sample. Back-to-back samples stream with no bubbles.
- Bounds sampling:
  - Bounds are read in S1, using register contents before the edge.
  - A cfg write in the same cycle as a sample does not affect that sample. It affects samples accepted one cycle later or after.
- Reset (asynchronous, takes effect immediately):
  - out_valid = 0, out_data = 0, out_flag = 00, out_ch = 0.
  - All pipeline valid bits = 0.
  - All lo = LO_INIT, all hi = HI_INIT.
  - All counters = 0.
  - Samples in flight when reset asserts are discarded, and no out_valid is produced for them.
- While out_valid = 0, out_data/out_flag/out_ch hold their last values.

## Configuration

- Macro: CLAMP_NAN_FLUSH_EN.
- Defined: a NaN input outputs the channel's lower bound with flag = 01, and the lower counter increments.
- Undefined: a NaN input passes through bit-exact with flag = 00, and no counter changes.

## Test plan

- Reset defaults:
  - After reset, ch0 input 0xC000000000000000 (-2.0) -> after 3 cycles, out = 0x0000000000000000, flag = 01, cnt_lo[0] = 1.
  - Input 0x7FF0000000000000 (+inf) -> out = +inf, flag = 00.
- Window clamp: program ch2 lo = 0x3FF8000000000000 (1.5), hi = 0x4014000000000000 (5.0), then stream 10.0 / 2.0 / -2.0:
  - 10.0 -> 5.0, flag = 10.
  - 2.0 -> 2.0, flag = 00.
  - -2.0 -> 1.5, flag = 01.
  - Outputs appear on consecutive cycles t+3..t+5.
- Interleaved channels:
  - Setup: ch0 hi = 1.5, ch1 hi = 10.0; alternate 5.0 on ch0/ch1 for 8 cycles.
  - ch0 outputs 1.5 with flag = 10; ch1 outputs 5.0 with flag = 00.
  - Counts: cnt_hi[0] = 4, cnt_hi[1] = 0.
- Same-cycle cfg write and sample: ch1 lo = 0 and input -2.0 on ch1 while writing lo = -5.0 (0xC014000000000000) -> out = 0.0. The next -2.0 -> out = -2.0.
- Counters, with CNT_W = 4:
  - 20 consecutive low clips -> cnt_lo holds 15 (no wrap).
  - cnt_clr asserted during a clip cycle -> cnt_lo = 0.
- NaN handling: input 0x7FF8000000000000 on ch0:
  - With CLAMP_NAN_FLUSH_EN -> out = lo, flag = 01.
  - Without -> out = 0x7FF8000000000000, flag = 00.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid stays 0 and no counter changes.
